// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Shares one external combinational ALU between NUM_REQ requesters. Requests are
// arbitrated round-robin behind valid/ready handshakes; the winner's select and
// operands are registered and presented to the ALU for one cycle (EXEC). The ALU
// output is then captured and held in RESP until the consumer accepts it.
//
// Optional feature: define ALU_ARB_NZP_EN to add the rsp_nzp_o port. It carries the
// LC-3 style {N,Z,P} condition codes of rsp_data_o.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req_valid_i    per-requester request
//   req_ready_o    one-hot grant, only ever non-zero in IDLE
//   req_select_i   per-requester ALU op, slice i is [2i+1:2i]
//   req_a_i/b_i    per-requester operands, slice i is [WIDTH*i +: WIDTH]
//   alu_select_o   to ALU select (00 ADD, 01 AND, 10 NOT a, 11 pass a)
//   alu_a_o/b_o    to ALU in_a/in_b
//   alu_out_i      from ALU out
//   rsp_valid_o    result available
//   rsp_id_o       index of the requester that owns the result
//   rsp_data_o     registered result
//   rsp_nzp_o      {N,Z,P} of rsp_data_o (ALU_ARB_NZP_EN only)
//   rsp_ready_i    consumer accepts the result

module alu_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [2*NUM_REQ-1:0]     req_select_i,
  input  logic [WIDTH*NUM_REQ-1:0] req_a_i,
  input  logic [WIDTH*NUM_REQ-1:0] req_b_i,
  output logic [1:0]               alu_select_o,
  output logic [WIDTH-1:0]         alu_a_o,
  output logic [WIDTH-1:0]         alu_b_o,
  input  logic [WIDTH-1:0]         alu_out_i,
  output logic                     rsp_valid_o,
  output logic [1:0]               rsp_id_o,
  output logic [WIDTH-1:0]         rsp_data_o,
`ifdef ALU_ARB_NZP_EN
  output logic [2:0]               rsp_nzp_o,
`endif
  input  logic                     rsp_ready_i
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;
`ifdef ALU_ARB_NZP_EN
  logic [2:0]       nzp_q, nzp_d;
  logic             alu_neg, alu_zero;
`endif

  logic [NUM_REQ-1:0] grant;
  logic [1:0]         grant_idx;
  logic               grant_found;
  int unsigned        scan_idx;

  // Round-robin pick: first valid requester scanning upward from last_q+1.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    scan_idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (32'(last_q) + k) % NUM_REQ;
      if (!grant_found && req_valid_i[scan_idx]) begin
        grant_found     = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx[1:0];
      end
    end
  end

  assign req_ready_o = (state_q == StIdle) ? grant : '0;

`ifdef ALU_ARB_NZP_EN
  assign alu_neg  = alu_out_i[WIDTH-1];
  assign alu_zero = (alu_out_i == '0);
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    data_d  = data_q;
`ifdef ALU_ARB_NZP_EN
    nzp_d   = nzp_q;
`endif
    unique case (state_q)
      StIdle: begin
        // A grant is always accepted: the winner's valid is high by construction.
        if (grant_found) begin
          state_d = StExec;
          last_d  = grant_idx;
          id_d    = grant_idx;
          sel_d   = req_select_i[2*int'(grant_idx) +: 2];
          a_d     = req_a_i[WIDTH*int'(grant_idx) +: WIDTH];
          b_d     = req_b_i[WIDTH*int'(grant_idx) +: WIDTH];
        end
      end
      StExec: begin
        state_d = StResp;
        data_d  = alu_out_i;
`ifdef ALU_ARB_NZP_EN
        nzp_d   = {alu_neg, alu_zero, !alu_neg && !alu_zero};
`endif
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= 2'(NUM_REQ - 1);
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      data_q  <= '0;
`ifdef ALU_ARB_NZP_EN
      nzp_q   <= 3'b010;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      data_q  <= data_d;
`ifdef ALU_ARB_NZP_EN
      nzp_q   <= nzp_d;
`endif
    end
  end

  // ALU inputs come straight from the operand registers, so they only move on an accept.
  assign alu_select_o = sel_q;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign rsp_valid_o  = (state_q == StResp);
  assign rsp_id_o     = id_q;
  assign rsp_data_o   = data_q;
`ifdef ALU_ARB_NZP_EN
  assign rsp_nzp_o    = nzp_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a 2-requester and a 4-requester instance, each with a
// behavioural ALU beside it. Expected responses are queued when stimulus is driven;
// a negedge monitor logs grants and response handshakes for the tests to compare.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
    logic [2:0]  nzp;
  } rsp_t;

  int tests_run = 0;
  int tests_failed = 0;

  // 2-requester instance
  logic [1:0]  rv2, rr2;
  logic [3:0]  rsel2;
  logic [31:0] ra2, rb2;
  logic [1:0]  asel2;
  logic [15:0] aa2, ab2, aout2, rspd2;
  logic        rspv2, rsprdy2;
  logic [1:0]  rspid2;
  logic [2:0]  nzp2;

  // 4-requester instance
  logic [3:0]  rv4, rr4;
  logic [7:0]  rsel4;
  logic [63:0] ra4, rb4;
  logic [1:0]  asel4;
  logic [15:0] aa4, ab4, aout4, rspd4;
  logic        rspv4, rsprdy4;
  logic [1:0]  rspid4;
  logic [2:0]  nzp4;

  function automatic logic [15:0] alu_f(input logic [1:0] s, input logic [15:0] a,
                                        input logic [15:0] b);
    case (s)
      2'b00:   return a + b;
      2'b01:   return a & b;
      2'b10:   return ~a;
      default: return a;
    endcase
  endfunction

  assign aout2 = alu_f(asel2, aa2, ab2);
  assign aout4 = alu_f(asel4, aa4, ab4);

  alu_arbiter #(.NUM_REQ(2), .WIDTH(16)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (rv2),
    .req_ready_o  (rr2),
    .req_select_i (rsel2),
    .req_a_i      (ra2),
    .req_b_i      (rb2),
    .alu_select_o (asel2),
    .alu_a_o      (aa2),
    .alu_b_o      (ab2),
    .alu_out_i    (aout2),
    .rsp_valid_o  (rspv2),
    .rsp_id_o     (rspid2),
    .rsp_data_o   (rspd2),
`ifdef ALU_ARB_NZP_EN
    .rsp_nzp_o    (nzp2),
`endif
    .rsp_ready_i  (rsprdy2)
  );

  alu_arbiter #(.NUM_REQ(4), .WIDTH(16)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (rv4),
    .req_ready_o  (rr4),
    .req_select_i (rsel4),
    .req_a_i      (ra4),
    .req_b_i      (rb4),
    .alu_select_o (asel4),
    .alu_a_o      (aa4),
    .alu_b_o      (ab4),
    .alu_out_i    (aout4),
    .rsp_valid_o  (rspv4),
    .rsp_id_o     (rspid4),
    .rsp_data_o   (rspd4),
`ifdef ALU_ARB_NZP_EN
    .rsp_nzp_o    (nzp4),
`endif
    .rsp_ready_i  (rsprdy4)
  );

`ifndef ALU_ARB_NZP_EN
  assign nzp2 = 3'b000;
  assign nzp4 = 3'b000;
`endif

  // Scoreboards (expected) and monitor logs (observed).
  rsp_t sb2_q[$], sb4_q[$], r2_q[$], r4_q[$];
  int   g2_q[$], g4_q[$];

  function automatic int oh2idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (|(rv2 & rr2)) g2_q.push_back(oh2idx({2'b00, rv2 & rr2}));
      if (rspv2 && rsprdy2) r2_q.push_back(rsp_t'({rspid2, rspd2, nzp2}));
      if (|(rv4 & rr4)) g4_q.push_back(oh2idx(rv4 & rr4));
      if (rspv4 && rsprdy4) r4_q.push_back(rsp_t'({rspid4, rspd4, nzp4}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops one observed and one expected entry; have=0 when either side is empty.
  task automatic pop_pair(input bit four, output rsp_t got, output rsp_t exp, output bit have);
    got = '0;
    exp = '0;
    have = 1'b0;
    if (!four && r2_q.size() > 0 && sb2_q.size() > 0) begin
      got = r2_q.pop_front(); exp = sb2_q.pop_front(); have = 1'b1;
    end else if (four && r4_q.size() > 0 && sb4_q.size() > 0) begin
      got = r4_q.pop_front(); exp = sb4_q.pop_front(); have = 1'b1;
    end
  endtask

  task automatic clear_logs();
    sb2_q.delete(); sb4_q.delete(); r2_q.delete(); r4_q.delete();
    g2_q.delete(); g4_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rv2 = '0; rsel2 = '0; ra2 = '0; rb2 = '0; rsprdy2 = 1'b0;
    rv4 = '0; rsel4 = '0; ra4 = '0; rb4 = '0; rsprdy4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests_run++; if (rr2 !== 2'b00) begin tests_failed++; $display("FAIL reset_ready: got %b want 00", rr2); end
    tests_run++; if ({asel2, aa2, ab2} !== 34'd0) begin tests_failed++; $display("FAIL reset_alu: got %h/%h/%h want 0", asel2, aa2, ab2); end
    tests_run++; if ({rspv2, rspid2, rspd2} !== 19'd0) begin tests_failed++; $display("FAIL reset_rsp: got v=%b id=%0d d=%h want 0", rspv2, rspid2, rspd2); end
`ifdef ALU_ARB_NZP_EN
    tests_run++; if (nzp2 !== 3'b010) begin tests_failed++; $display("FAIL reset_nzp: got %b want 010", nzp2); end
`endif
    #1 rv2 = 2'b01;
    #1;
    tests_run++; if (rr2 !== 2'b01) begin tests_failed++; $display("FAIL reset_first_grant: got %b want 01", rr2); end
    rv2 = 2'b00;
  endtask

  task automatic test_add();
    rsp_t got, exp; bit have;
    clear_logs();
    tick();
    rv2 = 2'b01; rsel2[1:0] = 2'b00; ra2[15:0] = 16'h0005; rb2[15:0] = 16'hFFFD;
    rsprdy2 = 1'b1;  // high early: must be ignored until RESP
    sb2_q.push_back(rsp_t'({2'd0, 16'h0002, 3'b001}));
    @(negedge clk);
    tests_run++; if (rr2 !== 2'b01) begin tests_failed++; $display("FAIL add_ready: got %b want 01", rr2); end
    tick();  // E0
    rv2 = 2'b00;
    @(negedge clk);
    tests_run++; if ({asel2, aa2, ab2} !== {2'b00, 16'h0005, 16'hFFFD}) begin tests_failed++; $display("FAIL add_exec_alu: got %b/%h/%h want 00/0005/fffd", asel2, aa2, ab2); end
    tests_run++; if ({rspv2, rr2} !== 3'b000) begin tests_failed++; $display("FAIL add_exec_idle_outs: got v=%b rdy=%b want 0/00", rspv2, rr2); end
    tick();  // E1
    @(negedge clk);
    tests_run++; if (rspv2 !== 1'b1) begin tests_failed++; $display("FAIL add_rsp_valid: got %b want 1", rspv2); end
    tick();  // E2
    @(negedge clk);
    tests_run++; if (rspv2 !== 1'b0) begin tests_failed++; $display("FAIL add_rsp_drop: got %b want 0", rspv2); end
    pop_pair(1'b0, got, exp, have);
    tests_run++; if (!have) begin tests_failed++; $display("FAIL add_rsp_count: got none want 1"); end
    else begin
      tests_run++; if ({got.id, got.data} !== {exp.id, exp.data}) begin tests_failed++; $display("FAIL add_rsp: got id=%0d d=%h want id=%0d d=%h", got.id, got.data, exp.id, exp.data); end
`ifdef ALU_ARB_NZP_EN
      tests_run++; if (got.nzp !== exp.nzp) begin tests_failed++; $display("FAIL add_nzp: got %b want %b", got.nzp, exp.nzp); end
`endif
    end
  endtask

  task automatic test_round_robin();
    rsp_t got, exp; bit have;
    do_reset();
    rsprdy2 = 1'b1; rv2 = 2'b11; rsel2 = 4'b1111;
    ra2 = {16'h8000, 16'h8000}; rb2 = {16'h1234, 16'h4321};
    for (int k = 0; k < 4; k++) sb2_q.push_back(rsp_t'({2'(k % 2), 16'h8000, 3'b100}));
    for (int c = 0; c < 40 && r2_q.size() < 4; c++) tick();
    rv2 = 2'b00;
    repeat (2) tick();
    tests_run++; if (g2_q.size() < 4) begin tests_failed++; $display("FAIL rr_grant_count: got %0d want 4", g2_q.size()); end
    else for (int k = 0; k < 4; k++) begin
      tests_run++; if (g2_q[k] != k % 2) begin tests_failed++; $display("FAIL rr_grant_order[%0d]: got %0d want %0d", k, g2_q[k], k % 2); end
    end
    for (int k = 0; k < 4; k++) begin
      pop_pair(1'b0, got, exp, have);
      tests_run++; if (!have) begin tests_failed++; $display("FAIL rr_rsp_count[%0d]: got none want one", k); end
      else begin
        tests_run++; if ({got.id, got.data} !== {exp.id, exp.data}) begin tests_failed++; $display("FAIL rr_rsp[%0d]: got id=%0d d=%h want id=%0d d=%h", k, got.id, got.data, exp.id, exp.data); end
`ifdef ALU_ARB_NZP_EN
        tests_run++; if (got.nzp !== exp.nzp) begin tests_failed++; $display("FAIL rr_nzp[%0d]: got %b want %b", k, got.nzp, exp.nzp); end
`endif
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_t got, exp; bit have;
    do_reset();
    rv2 = 2'b10; rsel2 = 4'b0100; ra2 = {16'h00F0, 16'h0001}; rb2 = {16'h0F0F, 16'h0001};
    sb2_q.push_back(rsp_t'({2'd1, 16'h0000, 3'b010}));
    @(negedge clk);
    tests_run++; if (rr2 !== 2'b10) begin tests_failed++; $display("FAIL bp_grant1: got %b want 10", rr2); end
    tick();  // req1 accepted
    rv2 = 2'b01;  // req0 now waits behind it
    @(negedge clk);
    tests_run++; if (rr2 !== 2'b00) begin tests_failed++; $display("FAIL bp_exec_ready: got %b want 00", rr2); end
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++; if ({rspv2, rspid2, rspd2, rr2} !== {1'b1, 2'd1, 16'h0000, 2'b00}) begin tests_failed++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d d=%h rdy=%b want 1/1/0000/00", c, rspv2, rspid2, rspd2, rr2); end
`ifdef ALU_ARB_NZP_EN
      tests_run++; if (nzp2 !== 3'b010) begin tests_failed++; $display("FAIL bp_hold_nzp[%0d]: got %b want 010", c, nzp2); end
`endif
      tick();
    end
    rsprdy2 = 1'b1;
    @(negedge clk);
    tests_run++; if (rr2 !== 2'b00) begin tests_failed++; $display("FAIL bp_ready_before_hs: got %b want 00", rr2); end
    tick();  // handshake
    @(negedge clk);
    tests_run++; if (rr2 !== 2'b01) begin tests_failed++; $display("FAIL bp_grant0_after: got %b want 01", rr2); end
    sb2_q.push_back(rsp_t'({2'd0, 16'h0002, 3'b001}));
    tick();
    rv2 = 2'b00;
    for (int c = 0; c < 10 && r2_q.size() < 2; c++) tick();
    for (int k = 0; k < 2; k++) begin
      pop_pair(1'b0, got, exp, have);
      tests_run++; if (!have) begin tests_failed++; $display("FAIL bp_rsp_count[%0d]: got none want one", k); end
      else begin
        tests_run++; if ({got.id, got.data} !== {exp.id, exp.data}) begin tests_failed++; $display("FAIL bp_rsp[%0d]: got id=%0d d=%h want id=%0d d=%h", k, got.id, got.data, exp.id, exp.data); end
      end
    end
  endtask

  task automatic test_not();
    rsp_t got, exp; bit have;
    clear_logs();
    tick();
    rsprdy2 = 1'b1; rv2 = 2'b01; rsel2[1:0] = 2'b10; ra2[15:0] = 16'hFFFF; rb2[15:0] = 16'h1234;
    sb2_q.push_back(rsp_t'({2'd0, 16'h0000, 3'b010}));
    tick();
    rv2 = 2'b00;
    @(negedge clk);
    tests_run++; if ({asel2, rspv2} !== 3'b100) begin tests_failed++; $display("FAIL not_exec: got sel=%b v=%b want 10/0", asel2, rspv2); end
    tick();
    @(negedge clk);
    tests_run++; if (rspv2 !== 1'b1) begin tests_failed++; $display("FAIL not_rsp_valid: got %b want 1", rspv2); end
    tick();
    pop_pair(1'b0, got, exp, have);
    tests_run++; if (!have) begin tests_failed++; $display("FAIL not_rsp_count: got none want one"); end
    else begin
      tests_run++; if ({got.id, got.data} !== {exp.id, exp.data}) begin tests_failed++; $display("FAIL not_rsp: got id=%0d d=%h want id=%0d d=%h", got.id, got.data, exp.id, exp.data); end
`ifdef ALU_ARB_NZP_EN
      tests_run++; if (got.nzp !== exp.nzp) begin tests_failed++; $display("FAIL not_nzp: got %b want %b", got.nzp, exp.nzp); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    rsp_t got, exp; bit have;
    clear_logs();
    tick();
    rsprdy2 = 1'b1; rv2 = 2'b01; rsel2 = 4'b1111; ra2 = {16'h2222, 16'hABCD};
    tick();  // accepted, last becomes 0
    rv2 = 2'b00;
    @(negedge clk);  // EXEC
    rst_n = 1'b0;
    #1;
    tests_run++; if ({rspv2, rspid2, rspd2, asel2, aa2, ab2} !== 53'd0) begin tests_failed++; $display("FAIL midrst_outs: got v=%b id=%0d d=%h alu=%b/%h/%h want 0", rspv2, rspid2, rspd2, asel2, aa2, ab2); end
`ifdef ALU_ARB_NZP_EN
    tests_run++; if (nzp2 !== 3'b010) begin tests_failed++; $display("FAIL midrst_nzp: got %b want 010", nzp2); end
`endif
    #1 rst_n = 1'b1;
    rv2 = 2'b11; ra2 = {16'h2222, 16'h1357};
    sb2_q.push_back(rsp_t'({2'd0, 16'h1357, 3'b001}));
    #1;
    tests_run++; if (rr2 !== 2'b01) begin tests_failed++; $display("FAIL midrst_grant: got %b want 01", rr2); end
    tick();
    rv2 = 2'b00;
    @(negedge clk);
    tests_run++; if (rspv2 !== 1'b0) begin tests_failed++; $display("FAIL midrst_no_rsp: got %b want 0", rspv2); end
    for (int c = 0; c < 10 && r2_q.size() < 1; c++) tick();
    repeat (3) tick();
    tests_run++; if (r2_q.size() != 1) begin tests_failed++; $display("FAIL midrst_rsp_count: got %0d want 1", r2_q.size()); end
    pop_pair(1'b0, got, exp, have);
    if (have) begin
      tests_run++; if ({got.id, got.data} !== {exp.id, exp.data}) begin tests_failed++; $display("FAIL midrst_rsp: got id=%0d d=%h want id=%0d d=%h", got.id, got.data, exp.id, exp.data); end
    end
  endtask

  task automatic test_four();
    rsp_t got, exp; bit have;
    int n0, pos;
    do_reset();
    rsprdy4 = 1'b1; rv4 = 4'b1111; rsel4 = '0;
    for (int i = 0; i < 4; i++) begin
      ra4[16*i +: 16] = 16'((i + 1) * 256);
      rb4[16*i +: 16] = 16'(i);
    end
    for (int k = 0; k < 5; k++)
      sb4_q.push_back(rsp_t'({2'(k % 4), 16'(((k % 4) + 1) * 256 + (k % 4)), 3'b001}));
    for (int c = 0; c < 60 && r4_q.size() < 5; c++) tick();
    rv4 = 4'b0000;
    repeat (2) tick();
    tests_run++; if (g4_q.size() < 5) begin tests_failed++; $display("FAIL four_grant_count: got %0d want 5", g4_q.size()); end
    else for (int k = 0; k < 5; k++) begin
      tests_run++; if (g4_q[k] != k % 4) begin tests_failed++; $display("FAIL four_grant_order[%0d]: got %0d want %0d", k, g4_q[k], k % 4); end
    end
    for (int k = 0; k < 5; k++) begin
      pop_pair(1'b1, got, exp, have);
      tests_run++; if (!have) begin tests_failed++; $display("FAIL four_rsp_count[%0d]: got none want one", k); end
      else begin
        tests_run++; if ({got.id, got.data} !== {exp.id, exp.data}) begin tests_failed++; $display("FAIL four_rsp[%0d]: got id=%0d d=%h want id=%0d d=%h", k, got.id, got.data, exp.id, exp.data); end
      end
    end
    // Late requester 2 joins after the first grant and must be served within 4 ops.
    do_reset();
    rsprdy4 = 1'b1; rv4 = 4'b1011;
    for (int c = 0; c < 20 && g4_q.size() < 1; c++) tick();
    rv4 = 4'b1111;
    n0 = g4_q.size();
    pos = -1;
    for (int c = 0; c < 60 && pos < 0; c++) begin
      tick();
      for (int k = n0; k < g4_q.size(); k++) if (pos < 0 && g4_q[k] == 2) pos = k;
    end
    rv4 = 4'b0000;
    repeat (6) tick();
    tests_run++; if (pos < 0 || pos - n0 >= 4) begin tests_failed++; $display("FAIL four_late_req2: got served after %0d ops want fewer than 4", (pos < 0) ? -1 : pos - n0 + 1); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_round_robin();
    test_backpressure();
    test_not();
    test_reset_mid();
    test_four();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
